// File: rtl/code_run_encoder_pkg.sv
// ============================================================================
// Module : code_run_pkg
// Desc   : Shared widths, record layout and tracker action encoding for the
//          code run-length encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package code_run_pkg;

    localparam int CODE_W = 2;
    localparam int VAL_W  = 3;
    localparam int CNT_W  = 8;
    localparam int REC_W  = CODE_W + VAL_W + CNT_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Record word is {code, val, len}, MSB to LSB.
    localparam int LEN_LSB  = 0;
    localparam int VAL_LSB  = CNT_W;
    localparam int CODE_LSB = CNT_W + VAL_W;

    typedef enum logic [2:0] {
        ACT_HOLD    = 3'd0,
        ACT_OPEN    = 3'd1,
        ACT_EXTEND  = 3'd2,
        ACT_RESTART = 3'd3,
        ACT_CLOSE   = 3'd4
    } run_act_t;

endpackage : code_run_pkg

`default_nettype wire

// File: rtl/code_run_encoder_if.sv
// ============================================================================
// Module : code_run_encoder_if
// Desc   : Sample input and record output bundle of the code run encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface code_run_encoder_if #(
    parameter int CODE_W = 2,
    parameter int VAL_W  = 3,
    parameter int CNT_W  = 8
);
    logic              in_en;
    logic [CODE_W-1:0] in_code;
    logic [VAL_W-1:0]  in_val;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [VAL_W-1:0]  out_val;
    logic [CNT_W-1:0]  out_len;
    logic              overflow;

    modport master (
        output in_en, in_code, in_val, flush, out_ready,
        input  out_valid, out_code, out_val, out_len, overflow
    );

    modport slave (
        input  in_en, in_code, in_val, flush, out_ready,
        output out_valid, out_code, out_val, out_len, overflow
    );
endinterface : code_run_encoder_if

`default_nettype wire

// File: rtl/code_run_encoder_run_fifo.sv
// ============================================================================
// Module : run_fifo
// Desc   : Synchronous record FIFO; a push into a full FIFO is accepted only
//          when a pop happens on the same edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module run_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [WIDTH-1:0]      o_head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // Full FIFO still takes a record when the head leaves on the same edge.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : run_fifo

`default_nettype wire

// File: rtl/code_run_encoder.sv
// ============================================================================
// Module : code_run_encoder
// Desc   : Run-length encodes consecutive (code, value) samples into
//          {code, val, len} records delivered through a small FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module code_run_encoder
    import code_run_pkg::*;
#(
    parameter int CODE_W = code_run_pkg::CODE_W,
    parameter int VAL_W  = code_run_pkg::VAL_W,
    parameter int CNT_W  = code_run_pkg::CNT_W,
    parameter int DEPTH  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    code_run_encoder_if.slave  bus
);
    localparam int c_REC_W    = CODE_W + VAL_W + CNT_W;
    localparam int c_VAL_LSB  = CNT_W;
    localparam int c_CODE_LSB = CNT_W + VAL_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic              r_run_active;
    logic [CODE_W-1:0] r_run_code;
    logic [VAL_W-1:0]  r_run_val;
    logic [CNT_W-1:0]  r_run_len;
    logic              r_flush_pend;
    logic              r_overflow;

    run_act_t          w_act;
    logic              w_same;
    logic              w_push;
    logic [c_REC_W-1:0] w_rec;
    logic [c_REC_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;

    assign w_same = (bus.in_code == r_run_code) && (bus.in_val == r_run_val);
    assign w_rec  = {r_run_code, r_run_val, r_run_len};

    // Every push emits the currently open run, so at most one push per edge.
    always_comb begin
        w_act  = ACT_HOLD;
        w_push = 1'b0;
        if (bus.in_en) begin
            if (!r_run_active) begin
                w_act = ACT_OPEN;
            end else if (w_same && (r_run_len != c_CNT_MAX)) begin
                w_act = ACT_EXTEND;
            end else begin
                w_act  = ACT_RESTART;
                w_push = 1'b1;
            end
        end else if ((bus.flush || r_flush_pend) && r_run_active) begin
            w_act  = ACT_CLOSE;
            w_push = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_active <= 1'b0;
            r_run_code   <= '0;
            r_run_val    <= '0;
            r_run_len    <= '0;
            r_flush_pend <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (w_act)
                ACT_OPEN, ACT_RESTART: begin
                    r_run_active <= 1'b1;
                    r_run_code   <= bus.in_code;
                    r_run_val    <= bus.in_val;
                    r_run_len    <= CNT_W'(1);
                end
                ACT_EXTEND: begin
                    r_run_len <= r_run_len + 1'b1;
                end
                ACT_CLOSE: begin
                    r_run_active <= 1'b0;
                    r_run_len    <= '0;
                end
                default: begin
                    r_run_active <= r_run_active;
                end
            endcase

            // A flush seen alongside a sample is deferred to the next idle edge.
            if (bus.in_en) begin
                if (bus.flush) begin
                    r_flush_pend <= 1'b1;
                end
            end else begin
                r_flush_pend <= 1'b0;
            end

            if (w_push && w_full && !bus.out_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    run_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (DEPTH)
    ) u_run_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_rec),
        .i_pop   (bus.out_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign bus.out_valid = !w_empty;
    assign bus.out_code  = w_head[c_CODE_LSB +: CODE_W];
    assign bus.out_val   = w_head[c_VAL_LSB +: VAL_W];
    assign bus.out_len   = w_head[0 +: CNT_W];
    assign bus.overflow  = r_overflow;

endmodule : code_run_encoder

`default_nettype wire

// File: tb/tb_code_run_encoder.sv
// ============================================================================
// Module : tb_code_run_encoder
// Desc   : Directed stimulus with a record scoreboard for code_run_encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_code_run_encoder;
    import code_run_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    code_run_encoder_if #(.CODE_W(CODE_W), .VAL_W(VAL_W), .CNT_W(CNT_W)) bus ();

    code_run_encoder #(
        .CODE_W (CODE_W),
        .VAL_W  (VAL_W),
        .CNT_W  (CNT_W),
        .DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [REC_W-1:0] exp_q [$];
    logic [REC_W-1:0] mon_got;
    logic [REC_W-1:0] mon_exp;

    function automatic logic [REC_W-1:0] mk(input int c, input int v, input int n);
        return {CODE_W'(c), VAL_W'(v), CNT_W'(n)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pops happen on the following rising edge; inputs change only just after it.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            mon_got = {bus.out_code, bus.out_val, bus.out_len};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_record: got %0h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("record", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int c, input int v);
        bus.in_en   = 1'b1;
        bus.in_code = CODE_W'(c);
        bus.in_val  = VAL_W'(v);
        step();
    endtask

    task automatic idle(input int n);
        bus.in_en = 1'b0;
        repeat (n) step();
    endtask

    task automatic close_run(input int c, input int v, input int n);
        exp_q.push_back(mk(c, v, n));
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        idle(4);
    endtask

    initial begin
        bus.in_en     = 1'b0;
        bus.in_code   = '0;
        bus.in_val    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) step();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_code", 32'(bus.out_code), 0);
        check("rst_len", 32'(bus.out_len), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        rst = 1'b1;

        // 1: five (1,2) then (3,4); record visible exactly in cycle 7
        for (int i = 0; i < 5; i++) begin
            sample(1, 2);
            check("t1_early_valid", 32'(bus.out_valid), 0);
        end
        exp_q.push_back(mk(1, 2, 5));
        sample(3, 4);
        check("t1_valid_c7", 32'(bus.out_valid), 1);
        idle(1);
        check("t1_valid_c8", 32'(bus.out_valid), 0);
        idle(3);
        check("t1_run_open", 32'(bus.out_valid), 0);

        // 2: 300 x (2,6) splits at the counter maximum
        exp_q.push_back(mk(3, 4, 1));
        for (int i = 0; i < 300; i++) begin
            if (i == 255) exp_q.push_back(mk(2, 6, 255));
            sample(2, 6);
        end
        close_run(2, 6, 45);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("t2_closed", 32'(bus.out_valid), 0);
        end
        check("t2_drained", 32'(exp_q.size()), 0);

        // 3: stalled consumer, fifth record dropped
        bus.out_ready = 1'b0;
        exp_q.push_back(mk(0, 1, 1));
        exp_q.push_back(mk(1, 1, 1));
        exp_q.push_back(mk(0, 1, 1));
        exp_q.push_back(mk(1, 1, 1));
        for (int i = 0; i < 5; i++) sample(i % 2, 1);
        check("t3_full_no_ovf", 32'(bus.overflow), 0);
        sample(1, 1);
        check("t3_overflow", 32'(bus.overflow), 1);
        bus.out_ready = 1'b1;
        idle(6);
        check("t3_overflow_sticky", 32'(bus.overflow), 1);
        check("t3_drained", 32'(exp_q.size()), 0);
        close_run(1, 1, 1);

        // 4: full FIFO with concurrent pop and push
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t4_ovf_cleared", 32'(bus.overflow), 0);
        bus.out_ready = 1'b0;
        exp_q.push_back(mk(0, 2, 1));
        exp_q.push_back(mk(1, 2, 1));
        exp_q.push_back(mk(0, 2, 1));
        exp_q.push_back(mk(1, 2, 1));
        for (int i = 0; i < 5; i++) sample(i % 2, 2);
        check("t4_full_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        exp_q.push_back(mk(0, 2, 1));
        sample(1, 2);
        check("t4_no_ovf", 32'(bus.overflow), 0);
        idle(6);
        check("t4_no_ovf_after", 32'(bus.overflow), 0);
        check("t4_drained", 32'(exp_q.size()), 0);
        close_run(1, 2, 1);

        // 5: flush with a sample waits for the idle edge
        for (int i = 0; i < 3; i++) sample(2, 3);
        bus.flush = 1'b1;
        sample(2, 3);
        bus.flush = 1'b0;
        check("t5_not_early", 32'(bus.out_valid), 0);
        exp_q.push_back(mk(2, 3, 4));
        idle(1);
        check("t5_valid", 32'(bus.out_valid), 1);
        idle(3);
        check("t5_drained", 32'(exp_q.size()), 0);

        // 6: asynchronous reset mid-cycle discards records and open run
        bus.out_ready = 1'b0;
        sample(3, 1);
        sample(3, 2);
        sample(3, 3);
        bus.in_en = 1'b0;
        check("t6_stored", 32'(bus.out_valid), 1);
        #3;
        rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.out_valid), 0);
        check("t6_async_len", 32'(bus.out_len), 0);
        check("t6_async_code", 32'(bus.out_code), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        exp_q.push_back(mk(3, 3, 1));
        sample(3, 3);
        sample(0, 0);
        idle(4);
        check("t6_no_stale", 32'(bus.out_valid), 0);
        check("final_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_code_run_encoder

`default_nettype wire

// File: doc/code_run_encoder.md
Name: code_run_encoder

Overview:
Downstream consumer of the lit-case state decoder. Each enabled cycle it samples the decoder's 2-bit `out` code and 3-bit `out_num` value, and run-length encodes consecutive identical (code, value) pairs. It emits records (code, value, run length) through a small FIFO with a valid/ready handshake to the trace/logging stage.

Parameters:
CODE_W, 2, width of sampled code (matches decoder `out`)
VAL_W, 3, width of sampled value (matches decoder `out_num`)
CNT_W, 8, run-length counter width; max run = 2^CNT_W-1
DEPTH, 4, record FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_en  input  1  sample in_code/in_val this cycle
in_code  input  CODE_W  code from decoder
in_val  input  VAL_W  value from decoder
flush  input  1  request emission of the open run
out_valid  output  1  FIFO head record valid
out_ready  input  1  consumer accepts head record
out_code  output  CODE_W  head record code
out_val  output  VAL_W  head record value
out_len  output  CNT_W  head record run length (1..2^CNT_W-1)
overflow  output  1  sticky: a record was dropped because FIFO full

Behaviour:
- Reset (rst=0, asynchronous): run_active=0, run_len=0, flush_pend=0, FIFO emptied, overflow=0. out_valid=0 immediately; out_code/out_val/out_len=0. Any open run and stored records are discarded.
- Run tracker, evaluated on each edge with in_en=1:
  - no open run: open run with (in_code, in_val), len=1.
  - open run, same code and value, len<max: len+1.
  - open run, same pair, len==max: push (code, val, max); new run len=1 with same pair.
  - open run, different code or value: push old run; new run len=1 with new pair.
- Flush:
  - flush with in_en=0: if a run is open, push it and set run_active=0; otherwise no effect.
  - flush with in_en=1: sample is processed normally and flush_pend is set.
  - flush_pend acts on the first edge with in_en=0, then clears.
  - At most one push per edge.
- FIFO: push on record emission; pop when out_valid && out_ready.
  - Record pushed at edge N: out_valid=1 and fields valid during cycle N+1.
  - Outputs come from the registered head; fields are 0 when empty.
- Full with pop in the same edge: push accepted, occupancy unchanged, no drop.
- Full without pop: record dropped, overflow set to 1. overflow clears only on reset.
- Empty: out_ready ignored; pointers do not move.
- Pointers wrap modulo DEPTH. Occupancy counter is width log2(DEPTH)+1 and saturates only by design, never exceeding DEPTH.
- Record payload ordering is {code, val, len} (MSB to LSB).

Decomposition:
- Package code_run_pkg holds:
  - CODE_W/VAL_W/CNT_W defaults
  - REC_W = CODE_W+VAL_W+CNT_W
  - CNT_MAX localparam
  - field offset constants for packing/unpacking the record word
- One sub-module, run_fifo: synchronous FIFO.
  - Parameters WIDTH=REC_W and DEPTH.
  - Ports: push/pop/full/empty/head, same clk/rst.
- The top level holds the run tracker, flush_pend and overflow logic.

Test Plan:
1. Reset release, in_en=1, (code 1, val 2) for 5 cycles then (3, 4) on cycle 6, out_ready=1 -> one record (1, 2, 5) with out_valid high exactly in cycle 7; run (3, 4) stays open.
2. 300 consecutive (2, 6) samples, then in_en=0 with flush=1 -> records (2, 6, 255) then (2, 6, 45); run_active=0 afterwards.
3. out_ready=0, DEPTH=4, six samples alternating (0, 1)/(1, 1) -> 5 records emitted, first 4 held, 5th dropped, overflow=1 and stays 1 after draining.
4. FIFO full, out_ready=1, new record closes on same edge -> no drop, occupancy stays 4, overflow stays 0; pop order preserved.
5. flush=1 together with in_en=1 (same pair as open run, len 3), then in_en=0 next cycle -> record (pair, 4) pushed on the idle edge, not earlier.
6. rst driven low mid-cycle with 2 records stored and a run open -> out_valid drops without a clock edge; after release, no stale records, and the first new run starts at len 1.
